// File: rtl/adc_pkg.sv
// Shared types and constants for the IR-sensor ADC scan controller.
package adc_pkg;

  // Converter result width and channel-select width.
  localparam int ADC_W = 16;
  localparam int CH_W  = 4;

  // Default ADC channel indices of the two IR sensors.
  localparam logic [CH_W-1:0] DEF_SIDE_CH = 4'd0;
  localparam logic [CH_W-1:0] DEF_DIAG_CH = 4'd1;

  // Scan sequencer states.
  //   IDLE  : scanning disabled, period timer held
  //   START : one-cycle conversion request
  //   CONV  : waiting for the converter (adc_done / timeout)
  //   ACC   : fold the captured sample into its channel accumulator
  //   PUB   : averaged codes are on the outputs with sample_valid high
  //   WAIT  : idle until the next period tick
  typedef enum logic [2:0] {
    IDLE,
    START,
    CONV,
    ACC,
    PUB,
    WAIT
  } scan_state_t;

endpackage : adc_pkg

// File: rtl/adc_period_timer.sv
// Free-running scan period timer. Counts 0..PERIOD_CYCLES-1 while run is
// high and pulses tick in the last count, so a scan started on a tick begins
// exactly PERIOD_CYCLES cycles after the previous one. Held at 0 while idle.
module adc_period_timer #(
  parameter int PERIOD_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int               CNT_W    = $clog2(PERIOD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Period counter: cleared while not running, wraps at the last count.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (!run || cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = run && (cnt_q == CNT_LAST);

endmodule : adc_period_timer

// File: rtl/adc_scan_ctrl.sv
// Shared-ADC scan controller for the side and diagonal IR sensors.
// Each scan period it issues an interleaved burst of conversions
// (side, diag, side, diag, ...), averages 2**AVG_LOG2 samples per channel and
// publishes the two signed codes together with a one-cycle sample_valid.
// A conversion that is not answered within TIMEOUT_CYCLES aborts the scan and
// raises the sticky adc_timeout flag; outputs keep their previous codes.
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int              PERIOD_CYCLES  = 50000,
  parameter int              AVG_LOG2       = 2,
  parameter int              TIMEOUT_CYCLES = 1000,
  parameter logic [CH_W-1:0] SIDE_CH        = DEF_SIDE_CH,
  parameter logic [CH_W-1:0] DIAG_CH        = DEF_DIAG_CH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  output logic                    adc_start,
  output logic [CH_W-1:0]         adc_channel,
  input  logic                    adc_done,
  input  logic signed [ADC_W-1:0] adc_data,
  output logic signed [ADC_W-1:0] side_adc_data,
  output logic signed [ADC_W-1:0] diag_adc_data,
  output logic                    sample_valid,
  output logic                    adc_timeout
);

  // Accumulator is wide enough for 2**AVG_LOG2 full-scale samples, so the
  // running sum can never overflow and the average always fits ADC_W bits.
  localparam int               ACC_W    = ADC_W + AVG_LOG2;
  localparam int               SMP_W    = AVG_LOG2 + 1;
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  scan_state_t             state_q, state_d;
  logic                    ch_q;          // 0 = side, 1 = diag
  logic [SMP_W-1:0]        smp_cnt_q;     // completed side+diag pairs
  logic [TMO_W-1:0]        tmo_cnt_q;     // cycles since adc_start
  logic signed [ADC_W-1:0] sample_q;      // result captured on adc_done
  logic signed [ACC_W-1:0] acc_side_q;
  logic signed [ACC_W-1:0] acc_diag_q;

  logic                    period_tick;
  logic                    timer_run;
  logic                    tmo_expire;
  logic                    last_sample;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] acc_side_nx;
  logic signed [ACC_W-1:0] acc_diag_nx;

  // The period timer runs from the first START of a burst until IDLE.
  assign timer_run = (state_q != IDLE);

  adc_period_timer #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_period_timer (
    .clk  (clk),
    .reset(reset),
    .run  (timer_run),
    .tick (period_tick)
  );

  // adc_done has priority: an answer in the expiry cycle is still accepted.
  assign tmo_expire  = (state_q == CONV) && !adc_done && (tmo_cnt_q >= TMO_LAST);
  // The diag sample of the final pair completes the scan.
  assign last_sample = ch_q && (smp_cnt_q == SMP_LAST);

  // Size cast of a signed value sign-extends into the accumulator width.
  assign sample_ext  = ACC_W'(sample_q);
  assign acc_side_nx = acc_side_q + sample_ext;
  assign acc_diag_nx = acc_diag_q + sample_ext;

  // Converter handshake is decoded straight from the state register so it
  // drops together with the asynchronous reset.
  assign adc_start   = (state_q == START);
  assign adc_channel = (state_q == START || state_q == CONV)
                       ? (ch_q ? DIAG_CH : SIDE_CH) : '0;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic of the scan sequencer.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = START;
      START:   state_d = CONV;
      CONV: begin
        if (adc_done)        state_d = ACC;
        else if (tmo_expire) state_d = WAIT;
      end
      ACC:     state_d = last_sample ? PUB : START;
      PUB:     state_d = WAIT;
      WAIT: begin
        if (!enable)          state_d = IDLE;
        else if (period_tick) state_d = START;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: timeout counter, sample capture, accumulation and publish.
  // The published codes and sample_valid are loaded on the edge leaving the
  // final ACC so that they are both visible in the PUB cycle, two cycles
  // after the final adc_done.
  // NOTE: the accumulators are plain flops, not RAM, so they take the same
  // asynchronous reset as the rest of the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_q          <= 1'b0;
      smp_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      sample_q      <= '0;
      acc_side_q    <= '0;
      acc_diag_q    <= '0;
      side_adc_data <= '0;
      diag_adc_data <= '0;
      sample_valid  <= 1'b0;
      adc_timeout   <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state_q)
        START: begin
          // The request cycle itself is the first counted cycle.
          tmo_cnt_q <= TMO_W'(1);
        end
        CONV: begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
          if (adc_done) begin
            sample_q <= adc_data;
          end else if (tmo_expire) begin
            // Abort: discard the partial burst, keep the old outputs.
            adc_timeout <= 1'b1;
            acc_side_q  <= '0;
            acc_diag_q  <= '0;
            smp_cnt_q   <= '0;
            ch_q        <= 1'b0;
          end
        end
        ACC: begin
          ch_q <= ~ch_q;
          if (!ch_q) begin
            acc_side_q <= acc_side_nx;
          end else begin
            acc_diag_q <= acc_diag_nx;
            smp_cnt_q  <= smp_cnt_q + 1'b1;
            if (last_sample) begin
              // Arithmetic shift: average rounds toward minus infinity.
              side_adc_data <= ADC_W'(acc_side_q >>> AVG_LOG2);
              diag_adc_data <= ADC_W'(acc_diag_nx >>> AVG_LOG2);
              sample_valid  <= 1'b1;
              adc_timeout   <= 1'b0;
            end
          end
        end
        PUB: begin
          acc_side_q <= '0;
          acc_diag_q <= '0;
          smp_cnt_q  <= '0;
          ch_q       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule : adc_scan_ctrl

// File: tb/tb_adc_scan_ctrl.sv
// Scoreboard bench for adc_scan_ctrl with a behavioural ADC model.
`timescale 1ns/1ps
module tb_adc_scan_ctrl;
  import adc_pkg::*;

  localparam int PERIOD   = 100;
  localparam int AVG_LOG2 = 2;
  localparam int TMO      = 20;
  localparam int NS       = 1 << AVG_LOG2;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               enable = 1'b0;
  logic               adc_done = 1'b0;
  logic signed [15:0] adc_data = '0;
  logic               adc_start;
  logic [3:0]         adc_channel;
  logic signed [15:0] side_adc_data;
  logic signed [15:0] diag_adc_data;
  logic               sample_valid;
  logic               adc_timeout;

  adc_scan_ctrl #(
    .PERIOD_CYCLES (PERIOD),
    .AVG_LOG2      (AVG_LOG2),
    .TIMEOUT_CYCLES(TMO),
    .SIDE_CH       (DEF_SIDE_CH),
    .DIAG_CH       (DEF_DIAG_CH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .adc_start    (adc_start),
    .adc_channel  (adc_channel),
    .adc_done     (adc_done),
    .adc_data     (adc_data),
    .side_adc_data(side_adc_data),
    .diag_adc_data(diag_adc_data),
    .sample_valid (sample_valid),
    .adc_timeout  (adc_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int side;
    int diag;
    int cyc;
  } exp_t;

  exp_t exp_q[$];     // expected publishes (ADC model -> monitor)
  int   tmo_q[$];     // expected timeout cycles
  int   dir_q[$];     // directed sample values, in conversion order
  int   tests = 0;
  int   fails = 0;
  int   start_count = 0;
  int   conv_idx = 0;
  int   pub_count = 0;
  int   epoch = 0;
  bit   stray_req = 1'b0;
  bit   tmo_req = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Mean rounded toward minus infinity.
  function automatic int floor_avg(input int s[$]);
    int sum = 0;
    int q;
    foreach (s[i]) sum += s[i];
    q = sum / NS;
    if ((sum % NS) != 0 && sum < 0) q -= 1;
    return q;
  endfunction

  // ADC model: answers each request after 1..8 cycles, checks channel order
  // and scan period, and predicts the published averages.
  initial begin : adc_model
    bit               busy = 1'b0;
    bit               stray_ack = 1'b0;
    bit               tmo_ack = 1'b0;
    bit               have_first = 1'b0;
    int               done_at = 0;
    int               last_first = 0;
    int               last_epoch = 0;
    logic [3:0]       chan = '0;
    logic signed [15:0] val = '0;
    int               side_s[$];
    int               diag_s[$];
    exp_t             e;
    forever begin
      @(posedge clk);
      #1;
      adc_done = 1'b0;
      if (!reset) begin
        busy = 1'b0;
        conv_idx = 0;
        side_s.delete();
        diag_s.delete();
        continue;
      end
      if (stray_req != stray_ack) begin
        stray_ack = stray_req;
        adc_done  = 1'b1;
        adc_data  = 16'($urandom);
      end
      if (adc_start) begin
        start_count++;
        check("start_while_busy", busy, 0);
        chan = (conv_idx % 2 == 0) ? DEF_SIDE_CH : DEF_DIAG_CH;
        check("start_channel", adc_channel, chan);
        if (conv_idx == 0) begin
          if (have_first && last_epoch == epoch) check("period", cyc - last_first, PERIOD);
          have_first = 1'b1;
          last_first = cyc;
          last_epoch = epoch;
        end
        if (conv_idx == 0 && tmo_req != tmo_ack) begin
          tmo_ack = tmo_req;
          tmo_q.push_back(cyc + TMO);
        end else begin
          busy    = 1'b1;
          done_at = cyc + int'($urandom_range(8, 1));
          val     = (dir_q.size() > 0) ? 16'(dir_q.pop_front()) : 16'($urandom);
        end
      end else if (busy) begin
        check("channel_stable", adc_channel, chan);
      end
      if (busy && cyc == done_at) begin
        busy     = 1'b0;
        adc_done = 1'b1;
        adc_data = val;
        if (conv_idx % 2 == 0) side_s.push_back(int'(val));
        else diag_s.push_back(int'(val));
        conv_idx++;
        if (conv_idx == 2 * NS) begin
          e.side = floor_avg(side_s);
          e.diag = floor_avg(diag_s);
          e.cyc  = cyc + 2;
          exp_q.push_back(e);
          side_s.delete();
          diag_s.delete();
          conv_idx = 0;
        end
      end
    end
  end

  // Monitor: compares every publish and timeout against the scoreboard and
  // checks that the outputs hold between publishes.
  initial begin : monitor
    int   last_s = 0;
    int   last_d = 0;
    bit   clr_chk = 1'b0;
    bit   tmo_prev = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        exp_q.delete();
        last_s = 0;
        last_d = 0;
        clr_chk = 1'b0;
        tmo_prev = 1'b0;
        continue;
      end
      if (clr_chk) begin
        check("timeout_cleared", adc_timeout, 0);
        clr_chk = 1'b0;
      end
      if (adc_timeout && !tmo_prev) begin
        check("timeout_expected", tmo_q.size() > 0, 1);
        if (tmo_q.size() > 0) check("timeout_cycle", cyc, tmo_q.pop_front());
      end
      tmo_prev = adc_timeout;
      if (sample_valid) begin
        pub_count++;
        check("valid_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("side_avg", side_adc_data, e.side);
          check("diag_avg", diag_adc_data, e.diag);
          check("valid_latency", cyc, e.cyc);
          last_s = e.side;
          last_d = e.diag;
        end
        clr_chk = 1'b1;
      end else begin
        check("side_hold", side_adc_data, last_s);
        check("diag_hold", diag_adc_data, last_d);
      end
    end
  end

  task automatic wait_pubs(input int n, input int budget, input string name);
    int target = pub_count + n;
    int c = 0;
    while (pub_count < target && c < budget) begin
      @(posedge clk);
      #2;
      c++;
    end
    check(name, pub_count >= target, 1);
  endtask

  task automatic wait_conv(input int idx, input int budget, input string name);
    int c = 0;
    do begin
      @(posedge clk);
      #2;
      c++;
    end while (!(adc_start && conv_idx == idx) && c < budget);
    check(name, adc_start && conv_idx == idx, 1);
  endtask

  task automatic enable_and_check_start(input string name);
    epoch++;
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #2;
    check(name, adc_start, 1);
  endtask

  task automatic push_scan(input int s0, input int d0, input int s1, input int d1,
                           input int s2, input int d2, input int s3, input int d3);
    dir_q.push_back(s0); dir_q.push_back(d0);
    dir_q.push_back(s1); dir_q.push_back(d1);
    dir_q.push_back(s2); dir_q.push_back(d2);
    dir_q.push_back(s3); dir_q.push_back(d3);
  endtask

  // Global watchdog.
  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int sc;
    int pc;
    int c;

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    check("rst_start", adc_start, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_side", side_adc_data, 0);
    check("rst_diag", diag_adc_data, 0);
    check("rst_timeout", adc_timeout, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    check("idle_no_start", start_count, 0);

    // Periodic random scans; the first starts at once.
    enable_and_check_start("first_start_immediate");
    wait_pubs(4, 600, "random_scans");

    // Directed averages, including rounding toward minus infinity.
    push_scan(100, -1, 101, -2, 102, -2, 103, -2);
    wait_pubs(1, 200, "directed_scan");
    check("directed_side", side_adc_data, 101);
    check("directed_diag", diag_adc_data, -2);
    push_scan(32767, -32768, 32767, -32768, 32767, -32768, 32767, -32768);
    wait_pubs(1, 200, "fullscale_scan");
    check("fullscale_side", side_adc_data, 32767);
    check("fullscale_diag", diag_adc_data, -32768);
    push_scan(-1, 1, -1, 1, -1, 1, -2, 0);
    wait_pubs(1, 200, "round_scan");
    check("round_side", side_adc_data, -2);
    check("round_diag", diag_adc_data, 0);

    // Unanswered conversion aborts one scan; the next good scan clears it.
    tmo_req = ~tmo_req;
    c = 0;
    while (!adc_timeout && c < 200) begin
      @(posedge clk);
      #2;
      c++;
    end
    check("timeout_raised", adc_timeout, 1);
    wait_pubs(1, 250, "scan_after_timeout");
    @(posedge clk);
    #2;
    check("timeout_cleared_after_pub", adc_timeout, 0);

    // enable dropped during the second conversion: scan still publishes.
    wait_conv(1, 200, "second_conversion");
    enable = 1'b0;
    wait_pubs(1, 200, "drop_still_publishes");
    sc = start_count;
    pc = pub_count;
    repeat (250) @(posedge clk);
    #2;
    check("drop_no_start", start_count, sc);
    check("drop_no_publish", pub_count, pc);

    // Reset asserted mid-CONV of a diag conversion.
    enable_and_check_start("restart_immediate");
    wait_pubs(2, 400, "scans_before_reset");
    wait_conv(1, 200, "diag_conv_before_reset");
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_start", adc_start, 0);
    check("async_rst_channel", adc_channel, 0);
    check("async_rst_side", side_adc_data, 0);
    check("async_rst_diag", diag_adc_data, 0);
    check("async_rst_valid", sample_valid, 0);
    check("async_rst_timeout", adc_timeout, 0);
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    sc = start_count;
    pc = pub_count;
    stray_req = ~stray_req;
    repeat (10) @(posedge clk);
    #2;
    check("stray_done_no_start", start_count, sc);
    check("stray_done_no_publish", pub_count, pc);
    enable_and_check_start("start_after_reset");
    wait_pubs(2, 400, "scans_after_reset");

    repeat (5) @(posedge clk);
    #2;
    check("exp_q_drained", exp_q.size(), 0);
    check("tmo_q_drained", tmo_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_adc_scan_ctrl
